// File: rtl/instruction_set_mem_if.sv
// Fetch-side bus of the instruction memory: program-load write port,
// program-counter read address, registered instruction and its decode.
interface instruction_set_mem_if;
  logic [3:0]  pc;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] inst;
  logic        inst_valid;
  logic [3:0]  func;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [7:0]  mem_addr;
  logic        is_alu;
  logic        is_mem;
  logic        is_branch;
  logic        illegal;

  modport master (
    output pc, we, waddr, wdata,
    input  inst, inst_valid, func, rs1, rs2, rd, mem_addr,
    input  is_alu, is_mem, is_branch, illegal
  );

  modport slave (
    input  pc, we, waddr, wdata,
    output inst, inst_valid, func, rs1, rs2, rd, mem_addr,
    output is_alu, is_mem, is_branch, illegal
  );
endinterface

// File: rtl/instruction_set_mem.sv
// 16 x 16-bit instruction memory for the Tomasulo core. Reset reloads a
// fixed default program; the write port lets a loader reprogram entries.
// The fetched word is registered and pre-decoded for the issue stage.
module instruction_set_mem (
  input  logic                        clk1,
  input  logic                        rst_n,
  instruction_set_mem_if.slave        bus
);

  logic [15:0] mem [16];
  logic [15:0] rd_word;
  logic [15:0] inst_p0;
  logic        vld_p0;

  // Default program image restored on every reset.
  function automatic logic [15:0] default_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h0123;
      4'd1:    w = 16'h1453;
      4'd2:    w = 16'h2676;
      4'd3:    w = 16'h3898;
      4'd4:    w = 16'h4A1B;
      4'd5:    w = 16'h5C2D;
      4'd6:    w = 16'h6122;
      4'd7:    w = 16'h7343;
      default: w = 16'hF000;
    endcase
    return w;
  endfunction

  // A write to the address being fetched is forwarded so the fetch sees the new word.
  always_comb begin
    rd_word = mem[bus.pc];
    if (bus.we && (bus.waddr == bus.pc)) rd_word = bus.wdata;
  end

  // Storage: reset reloads the default image and overrides any concurrent write.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= default_word(4'(i));
    end else if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Fetch stage: one-cycle registered read of mem[pc].
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      inst_p0 <= 16'h0000;
      vld_p0  <= 1'b0;
    end else begin
      inst_p0 <= rd_word;
      vld_p0  <= 1'b1;
    end
  end

  assign bus.inst       = inst_p0;
  assign bus.inst_valid = vld_p0;
  assign bus.func       = inst_p0[15:12];
  assign bus.rs1        = inst_p0[11:8];
  assign bus.rs2        = inst_p0[7:4];
  assign bus.rd         = inst_p0[3:0];
  assign bus.mem_addr   = inst_p0[11:4];
  // Opcode classes partition func into four disjoint ranges, so exactly one flag is high.
  assign bus.is_alu     = (inst_p0[15:14] == 2'b00);
  assign bus.is_mem     = (inst_p0[15:13] == 3'b010);
  assign bus.is_branch  = (inst_p0[15:13] == 3'b011);
  assign bus.illegal    = inst_p0[15];

endmodule

// File: tb/tb_instruction_set_mem.sv
// Self-checking bench for instruction_set_mem: directed scenarios plus a
// randomized run against an array-based model of the memory.
module tb_instruction_set_mem;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] ref_mem [16];
  logic [15:0] exp_inst;

  instruction_set_mem_if bus ();

  instruction_set_mem dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic load_defaults();
    int prog [8] = '{'h0123, 'h1453, 'h2676, 'h3898, 'h4A1B, 'h5C2D, 'h6122, 'h7343};
    for (int i = 0; i < 16; i++) ref_mem[i] = (i < 8) ? 16'(prog[i]) : 16'hF000;
  endtask

  // Drive one fetch cycle and advance the model; outputs are settled on return.
  task automatic step(input logic [3:0] p, input logic w, input logic [3:0] wa, input logic [15:0] wd);
    @(negedge clk1);
    bus.pc = p; bus.we = w; bus.waddr = wa; bus.wdata = wd;
    @(posedge clk1);
    exp_inst = (w && wa == p) ? wd : ref_mem[p];
    if (w) ref_mem[wa] = wd;
    #1;
    bus.we = 1'b0;
  endtask

  task automatic test_reset();
    bus.pc = 4'd0; bus.we = 1'b0; bus.waddr = 4'd0; bus.wdata = 16'h0;
    rst_n = 1'b0;
    load_defaults();
    #12;
    n_checks++;
    if (bus.inst !== 16'h0000 || bus.inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: inst=%h valid=%b, expected inst=0000 valid=0", bus.inst, bus.inst_valid);
    end
    n_checks++;
    if ({bus.is_alu, bus.is_mem, bus.is_branch, bus.illegal} !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_flags: flags=%b, expected 1000", {bus.is_alu, bus.is_mem, bus.is_branch, bus.illegal});
    end
    @(negedge clk1);
    rst_n = 1'b1;
    step(4'd0, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'h0123 || bus.inst_valid !== 1'b1 || bus.func !== 4'd0 || bus.rs1 !== 4'd1 ||
        bus.rs2 !== 4'd2 || bus.rd !== 4'd3 || bus.is_alu !== 1'b1) begin
      n_errors++;
      $display("FAIL first_fetch: inst=%h valid=%b func=%h rs1=%h rs2=%h rd=%h alu=%b, expected 0123 1 0 1 2 3 1",
               bus.inst, bus.inst_valid, bus.func, bus.rs1, bus.rs2, bus.rd, bus.is_alu);
    end
  endtask

  task automatic test_default_sweep();
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0, 4'd0, 16'h0);
      n_checks++;
      if (bus.inst !== ref_mem[i] || bus.inst_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL sweep_pc%0d: inst=%h valid=%b, expected %h 1", i, bus.inst, bus.inst_valid, ref_mem[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.inst !== 16'h4A1B || bus.mem_addr !== 8'hA1 || bus.rd !== 4'hB || bus.is_mem !== 1'b1) begin
          n_errors++;
          $display("FAIL sweep_load: inst=%h addr=%h rd=%h mem=%b, expected 4A1B A1 B 1",
                   bus.inst, bus.mem_addr, bus.rd, bus.is_mem);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (bus.inst !== 16'h6122 || bus.is_branch !== 1'b1) begin
          n_errors++;
          $display("FAIL sweep_branch: inst=%h branch=%b, expected 6122 1", bus.inst, bus.is_branch);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (bus.inst !== 16'hF000 || bus.illegal !== 1'b1 || bus.is_alu !== 1'b0) begin
          n_errors++;
          $display("FAIL sweep_illegal: inst=%h illegal=%b alu=%b, expected F000 1 0", bus.inst, bus.illegal, bus.is_alu);
        end
      end
    end
  endtask

  task automatic test_forward();
    step(4'd3, 1'b1, 4'd3, 16'h5ABC);
    n_checks++;
    if (bus.inst !== 16'h5ABC || bus.is_mem !== 1'b1) begin
      n_errors++;
      $display("FAIL forward_same_edge: inst=%h mem=%b, expected 5ABC 1", bus.inst, bus.is_mem);
    end
    step(4'd0, 1'b0, 4'd0, 16'h0);
    step(4'd3, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'h5ABC) begin
      n_errors++;
      $display("FAIL forward_stored: inst=%h, expected 5ABC", bus.inst);
    end
  endtask

  task automatic test_write_other();
    step(4'd2, 1'b1, 4'd8, 16'h0777);
    n_checks++;
    if (bus.inst !== 16'h2676) begin
      n_errors++;
      $display("FAIL write_other_read: inst=%h, expected 2676", bus.inst);
    end
    step(4'd8, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'h0777 || bus.illegal !== 1'b0 || bus.is_alu !== 1'b1) begin
      n_errors++;
      $display("FAIL write_other_stored: inst=%h illegal=%b alu=%b, expected 0777 0 1", bus.inst, bus.illegal, bus.is_alu);
    end
  endtask

  task automatic test_mid_reset();
    step(4'd5, 1'b0, 4'd0, 16'h0);
    #3;
    rst_n = 1'b0;
    load_defaults();
    #1;
    n_checks++;
    if (bus.inst !== 16'h0000 || bus.inst_valid !== 1'b0 || bus.is_alu !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_async: inst=%h valid=%b alu=%b, expected 0000 0 1", bus.inst, bus.inst_valid, bus.is_alu);
    end
    // Write attempted while reset is held must be discarded.
    @(negedge clk1);
    bus.pc = 4'd0; bus.we = 1'b1; bus.waddr = 4'd0; bus.wdata = 16'hDEAD;
    @(posedge clk1);
    #1;
    n_checks++;
    if (bus.inst !== 16'h0000 || bus.inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: inst=%h valid=%b, expected 0000 0", bus.inst, bus.inst_valid);
    end
    @(negedge clk1);
    bus.we = 1'b0;
    rst_n = 1'b1;
    step(4'd3, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'h3898) begin
      n_errors++;
      $display("FAIL restore_pc3: inst=%h, expected 3898", bus.inst);
    end
    step(4'd8, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'hF000) begin
      n_errors++;
      $display("FAIL restore_pc8: inst=%h, expected F000", bus.inst);
    end
    step(4'd0, 1'b0, 4'd0, 16'h0);
    n_checks++;
    if (bus.inst !== 16'h0123) begin
      n_errors++;
      $display("FAIL write_in_reset_ignored: inst=%h, expected 0123", bus.inst);
    end
  endtask

  task automatic test_random();
    int exp_func;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] p;
      logic [3:0] wa;
      logic       w;
      p  = 4'($urandom_range(0, 15));
      w  = ($urandom_range(0, 1) == 1);
      wa = ($urandom_range(0, 3) == 0) ? p : 4'($urandom_range(0, 15));
      step(p, w, wa, 16'($urandom));
      exp_func = int'(exp_inst) / 4096;
      n_checks++;
      if (bus.inst !== exp_inst || bus.inst_valid !== 1'b1 || bus.func !== 4'(exp_func) ||
          bus.rs1 !== 4'((int'(exp_inst) / 256) % 16) || bus.rs2 !== 4'((int'(exp_inst) / 16) % 16) ||
          bus.rd !== 4'(int'(exp_inst) % 16) || bus.mem_addr !== 8'((int'(exp_inst) / 16) % 256)) begin
        n_errors++;
        $display("FAIL random_fetch[%0d]: pc=%h inst=%h valid=%b mem_addr=%h, expected inst=%h valid=1",
                 n, p, bus.inst, bus.inst_valid, bus.mem_addr, exp_inst);
      end
      n_checks++;
      if (bus.is_alu !== (exp_func <= 3) || bus.is_mem !== (exp_func == 4 || exp_func == 5) ||
          bus.is_branch !== (exp_func == 6 || exp_func == 7) || bus.illegal !== (exp_func >= 8)) begin
        n_errors++;
        $display("FAIL random_class[%0d]: func=%0d flags=%b", n, exp_func,
                 {bus.is_alu, bus.is_mem, bus.is_branch, bus.illegal});
      end
    end
    // Read back the whole memory image after the random writes.
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0, 4'd0, 16'h0);
      n_checks++;
      if (bus.inst !== ref_mem[i]) begin
        n_errors++;
        $display("FAIL random_readback[%0d]: inst=%h, expected %h", i, bus.inst, ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_sweep();
    test_forward();
    test_write_other();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
